// File: rtl/cpu_debug_step_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_debug_step_ctrl
// Run/step controller and register readout for a single-cycle core's debug
// port. A conditioned press of switch_run starts one step, N steps or a free
// run by gating the core clock-enable. After every stop an optional scan
// streams a register range out over a valid/ready port.
//
// Optional feature macro: CPU_DEBUG_BREAKPOINT_EN (PC breakpoint, bp_* ports).
//
// Ports:
//   fastclk, reset      system clock, synchronous active-high reset
//   switch_run          raw run/step switch (asynchronous)
//   run_mode            00 step, 01 step N, 10 free run, 11 halt
//   step_n              step count for mode 01 (0 treated as 1)
//   swith_select        manual readout register address
//   scan_en             scan register range after each stop
//   cpu_clk_en          core clock-enable
//   dbg_addr/dbg_rdata  core debug read port (combinational read)
//   reg_read_data_1     registered manual readout
//   scan_valid/ready    scan word handshake; scan_addr/scan_data payload
//   busy                controller not idle
//   step_total          enabled core cycles since reset (wraps)
//   pc_in, bp_addr, bp_en, bp_hit   breakpoint (macro only)
// ---------------------------------------------------------------------------
module cpu_debug_step_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned STEP_W  = 16,
    parameter int unsigned SCAN_LO = 8,
    parameter int unsigned SCAN_HI = 25
) (
    input  logic              fastclk,
    input  logic              reset,
    input  logic              switch_run,
    input  logic [1:0]        run_mode,
    input  logic [STEP_W-1:0] step_n,
    input  logic [ADDR_W-1:0] swith_select,
    input  logic              scan_en,
    output logic              cpu_clk_en,
    output logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_rdata,
    output logic [DATA_W-1:0] reg_read_data_1,
    output logic              scan_valid,
    input  logic              scan_ready,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              busy,
    output logic [STEP_W-1:0] step_total
`ifdef CPU_DEBUG_BREAKPOINT_EN
    ,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] bp_addr,
    input  logic              bp_en,
    output logic              bp_hit
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_SCAN = 2'd3;

    localparam logic [ADDR_W-1:0] PTR_LO = ADDR_W'(SCAN_LO);
    localparam logic [ADDR_W-1:0] PTR_HI = ADDR_W'(SCAN_HI);

    logic [1:0]        state_q, state_d;
    logic [2:0]        sync_q;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              scan_valid_q, scan_valid_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic [DATA_W-1:0] scan_data_q, scan_data_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [STEP_W-1:0] total_q, total_d;

    logic       go;
    logic       run_en;
    logic       bp_match;
    logic [1:0] stop_state;

    // Rising edge of the twice-synchronised switch; one press gives one go.
    assign go = sync_q[1] & ~sync_q[2];

    assign run_en     = (state_q == S_STEP) || (state_q == S_RUN);
    assign stop_state = scan_en ? S_SCAN : S_IDLE;

`ifdef CPU_DEBUG_BREAKPOINT_EN
    logic first_q;
    logic bp_hit_q, bp_hit_d;

    // Match ignored in the first active cycle so a stopped core can resume.
    assign bp_match = run_en && bp_en && (pc_in == bp_addr) && !first_q;
    assign bp_hit   = bp_hit_q;

    always_comb begin
        bp_hit_d = bp_hit_q;
        if (bp_match) begin
            bp_hit_d = 1'b1;
        end else if (go && (state_q == S_IDLE)) begin
            bp_hit_d = 1'b0;
        end
    end

    always_ff @(posedge fastclk) begin
        if (reset) begin
            first_q  <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            first_q  <= (state_q == S_IDLE);
            bp_hit_q <= bp_hit_d;
        end
    end
`else
    assign bp_match = 1'b0;
`endif

    // Enable decoded from state flops only (breakpoint gating aside).
    assign cpu_clk_en = run_en & ~bp_match;

    // Next-state and datapath logic.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        ptr_d        = ptr_q;
        scan_valid_d = scan_valid_q;
        scan_addr_d  = scan_addr_q;
        scan_data_d  = scan_data_q;
        rd1_d        = rd1_q;
        total_d      = total_q + STEP_W'(cpu_clk_en);
        dbg_addr     = swith_select;

        case (state_q)
            S_IDLE: begin
                rd1_d = dbg_rdata;
                if (go) begin
                    case (run_mode)
                        2'b00: begin
                            remaining_d = STEP_W'(1);
                            state_d     = S_STEP;
                        end
                        2'b01: begin
                            remaining_d = (step_n == '0) ? STEP_W'(1) : step_n;
                            state_d     = S_STEP;
                        end
                        2'b10: state_d = S_RUN;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_STEP: begin
                remaining_d = remaining_q - STEP_W'(1);
                if ((remaining_q == STEP_W'(1)) || bp_match) begin
                    state_d = stop_state;
                    ptr_d   = PTR_LO;
                end
            end
            S_RUN: begin
                if (go || (run_mode == 2'b11) || bp_match) begin
                    state_d = stop_state;
                    ptr_d   = PTR_LO;
                end
            end
            default: begin
                // Alternate capture and handshake: at most one word per two cycles.
                dbg_addr = ptr_q;
                if (!scan_valid_q) begin
                    scan_valid_d = 1'b1;
                    scan_addr_d  = ptr_q;
                    scan_data_d  = dbg_rdata;
                end else if (scan_ready) begin
                    scan_valid_d = 1'b0;
                    if (ptr_q == PTR_HI) begin
                        state_d = S_IDLE;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sync_q       <= '0;
            remaining_q  <= '0;
            ptr_q        <= '0;
            scan_valid_q <= 1'b0;
            scan_addr_q  <= '0;
            scan_data_q  <= '0;
            rd1_q        <= '0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[1:0], switch_run};
            remaining_q  <= remaining_d;
            ptr_q        <= ptr_d;
            scan_valid_q <= scan_valid_d;
            scan_addr_q  <= scan_addr_d;
            scan_data_q  <= scan_data_d;
            rd1_q        <= rd1_d;
            total_q      <= total_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign reg_read_data_1 = rd1_q;
    assign scan_valid      = scan_valid_q;
    assign scan_addr       = scan_addr_q;
    assign scan_data       = scan_data_q;
    assign step_total      = total_q;

endmodule

// File: tb/tb_cpu_debug_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_debug_step_ctrl
// Scoreboard bench: the driver predicts each enable burst (start cycle and
// length) and each scan word when it presses the switch; independent
// monitors pop and compare when the DUT shows a burst or a scan word.
// ---------------------------------------------------------------------------
module tb_cpu_debug_step_ctrl;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned STEP_W  = 16;
    localparam int unsigned SCAN_LO = 8;
    localparam int unsigned SCAN_HI = 25;

    logic              fastclk = 1'b0;
    logic              reset;
    logic              switch_run;
    logic [1:0]        run_mode;
    logic [STEP_W-1:0] step_n;
    logic [ADDR_W-1:0] swith_select;
    logic              scan_en;
    logic              cpu_clk_en;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_rdata;
    logic [DATA_W-1:0] reg_read_data_1;
    logic              scan_valid;
    logic              scan_ready;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] scan_data;
    logic              busy;
    logic [STEP_W-1:0] step_total;
`ifdef CPU_DEBUG_BREAKPOINT_EN
    logic [DATA_W-1:0] pc_in   = '0;
    logic [DATA_W-1:0] bp_addr = '0;
    logic              bp_en   = 1'b0;
    logic              bp_hit;
`endif

    cpu_debug_step_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STEP_W(STEP_W),
        .SCAN_LO(SCAN_LO), .SCAN_HI(SCAN_HI)
    ) dut (
        .fastclk(fastclk), .reset(reset), .switch_run(switch_run),
        .run_mode(run_mode), .step_n(step_n), .swith_select(swith_select),
        .scan_en(scan_en), .cpu_clk_en(cpu_clk_en), .dbg_addr(dbg_addr),
        .dbg_rdata(dbg_rdata), .reg_read_data_1(reg_read_data_1),
        .scan_valid(scan_valid), .scan_ready(scan_ready),
        .scan_addr(scan_addr), .scan_data(scan_data), .busy(busy),
        .step_total(step_total)
`ifdef CPU_DEBUG_BREAKPOINT_EN
        , .pc_in(pc_in), .bp_addr(bp_addr), .bp_en(bp_en), .bp_hit(bp_hit)
`endif
    );

    always #5 fastclk = ~fastclk;

    // Core register file seen through the debug port.
    logic [DATA_W-1:0] regs [0:(1<<ADDR_W)-1];
    assign dbg_rdata = regs[dbg_addr];

    typedef struct { int start; int len; } burst_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } word_t;

    burst_t exp_burst[$];
    word_t  exp_scan[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stall_left = 0;
    logic [STEP_W-1:0] model_total;
    logic [DATA_W-1:0] held_exp;

    always @(posedge fastclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Enable-burst monitor.
    int     run_start = 0;
    int     run_len   = 0;
    bit     prev_en   = 1'b0;
    burst_t b;
    always @(negedge fastclk) begin
        if (cpu_clk_en === 1'b1) begin
            if (!prev_en) begin
                run_start = cyc;
                run_len   = 0;
            end
            run_len++;
        end else if (prev_en) begin
            if (exp_burst.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL burst: unexpected enable burst start %0d len %0d", run_start, run_len);
            end else begin
                b = exp_burst.pop_front();
                check("burst_start", 64'(run_start), 64'(b.start));
                check("burst_len", 64'(run_len), 64'(b.len));
            end
        end
        prev_en = (cpu_clk_en === 1'b1);
    end

    // Scan-word monitor with stall-stability check.
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    bit                have_h = 1'b0;
    word_t             w;
    always @(negedge fastclk) begin
        if (scan_valid === 1'b1) begin
            if (have_h) begin
                check("stall_addr", 64'(scan_addr), 64'(h_addr));
                check("stall_data", 64'(scan_data), 64'(h_data));
            end
            if (scan_ready === 1'b1) begin
                have_h = 1'b0;
                if (exp_scan.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scan: unexpected word addr %0d data %0h", scan_addr, scan_data);
                end else begin
                    w = exp_scan.pop_front();
                    check("scan_addr", 64'(scan_addr), 64'(w.addr));
                    check("scan_data", 64'(scan_data), 64'(w.data));
                    check("readout_hold", 64'(reg_read_data_1), 64'(held_exp));
                end
            end else begin
                have_h = 1'b1;
                h_addr = scan_addr;
                h_data = scan_data;
            end
        end else if (have_h) begin
            checks++;
            errors++;
            $display("FAIL scan_hold: scan_valid got 0 expected 1 while stalled");
            have_h = 1'b0;
        end
    end

    // scan_ready driver: optional forced stall, otherwise random back-pressure.
    initial begin
        scan_ready = 1'b0;
        forever begin
            @(posedge fastclk);
            #1;
            if (stall_left > 0 && scan_valid === 1'b1) begin
                scan_ready = 1'b0;
                stall_left--;
            end else begin
                scan_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic press_on(output int c);
        @(posedge fastclk);
        #1;
        switch_run = 1'b1;
        c = cyc;
    endtask

    task automatic press_off(input int h);
        repeat (h) @(posedge fastclk);
        #1;
        switch_run = 1'b0;
    endtask

    task automatic push_scan();
        word_t x;
        for (int a = SCAN_LO; a <= SCAN_HI; a++) begin
            x.addr = ADDR_W'(a);
            x.data = regs[a];
            exp_scan.push_back(x);
        end
    endtask

    task automatic push_burst(input int start, input int len);
        burst_t x;
        x.start = start;
        x.len   = len;
        exp_burst.push_back(x);
        model_total = model_total + STEP_W'(len);
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (6) @(posedge fastclk);
        while (busy !== 1'b0 && n < 3000) begin
            @(posedge fastclk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL wait_idle: busy got 1 expected 0 after %0d cycles", n);
        end
        @(negedge fastclk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cpu_clk_en"}, 64'(cpu_clk_en), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_scan_valid"}, 64'(scan_valid), 64'(0));
        check({tag, "_scan_addr"}, 64'(scan_addr), 64'(0));
        check({tag, "_scan_data"}, 64'(scan_data), 64'(0));
        check({tag, "_readout"}, 64'(reg_read_data_1), 64'(0));
        check({tag, "_step_total"}, 64'(step_total), 64'(0));
        check({tag, "_dbg_addr"}, 64'(dbg_addr), 64'(0));
    endtask

    task automatic readout(input logic [ADDR_W-1:0] sel);
        @(negedge fastclk);
        swith_select = sel;
        @(negedge fastclk);
        check("readout", 64'(reg_read_data_1), 64'(regs[sel]));
        held_exp = regs[sel];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2, len, h, r, mode;
        bit sc;
        reset        = 1'b1;
        switch_run   = 1'b0;
        run_mode     = 2'b00;
        step_n       = '0;
        swith_select = '0;
        scan_en      = 1'b0;
        model_total  = '0;
        held_exp     = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) regs[i] = $urandom;

        repeat (3) @(posedge fastclk);
        @(negedge fastclk);
        check_zero("reset");
        reset = 1'b0;

        // Single step, switch held 4 cycles.
        readout(ADDR_W'(3));
        run_mode = 2'b00;
        press_on(c);
        push_burst(c + 3, 1);
        press_off(4);
        wait_idle();
        check("step_total_single", 64'(step_total), 64'(1));

        // Step 5 with a second press while stepping; it is dropped.
        run_mode = 2'b01;
        step_n   = STEP_W'(5);
        press_on(c);
        push_burst(c + 3, 5);
        press_off(2);
        press_on(c2);
        press_off(2);
        wait_idle();
        check("step_total_n5", 64'(step_total), 64'(model_total));

        // step_n = 0 behaves as 1.
        step_n = '0;
        press_on(c);
        push_burst(c + 3, 1);
        press_off(3);
        wait_idle();

        // Free run stopped by a second press 100 cycles later.
        run_mode = 2'b10;
        press_on(c);
        press_off(3);
        repeat (96) @(posedge fastclk);
        press_on(c2);
        push_burst(c + 3, c2 - c);
        press_off(3);
        wait_idle();
        check("run_len_100", 64'(c2 - c), 64'(100));
        check("step_total_run", 64'(step_total), 64'(model_total));

        // Single step with scan, word 0 stalled 3 cycles.
        readout(ADDR_W'(16));
        run_mode = 2'b00;
        scan_en  = 1'b1;
        stall_left = 3;
        press_on(c);
        push_burst(c + 3, 1);
        push_scan();
        press_off(4);
        wait_idle();
        check("scan_drained", 64'(exp_scan.size()), 64'(0));

        // Randomised transactions.
        for (int t = 0; t < 25; t++) begin
            @(negedge fastclk);
            for (int i = 0; i < (1 << ADDR_W); i++) regs[i] = $urandom;
            readout(ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)));
            mode     = $urandom_range(0, 3);
            sc       = 1'($urandom_range(0, 1));
            run_mode = 2'(mode);
            scan_en  = sc;
            step_n   = STEP_W'($urandom_range(0, 14));
            h        = $urandom_range(2, 4);
            len      = (mode == 0) ? 1 : ((step_n == 0) ? 1 : int'(step_n));
            press_on(c);
            if (mode < 2) push_burst(c + 3, len);
            if (sc && mode != 3) push_scan();
            press_off(h);
            if (mode == 2) begin
                repeat ($urandom_range(3, 40)) @(posedge fastclk);
                press_on(c2);
                push_burst(c + 3, c2 - c);
                press_off(h);
            end else if (mode < 2 && (sc || len >= 12) && $urandom_range(0, 1) == 1) begin
                press_on(c2);
                press_off(2);
            end
            wait_idle();
            check("step_total_rand", 64'(step_total), 64'(model_total));
        end

        // Reset during free run.
        scan_en  = 1'b0;
        run_mode = 2'b10;
        press_on(c);
        press_off(3);
        repeat (10) @(posedge fastclk);
        @(negedge fastclk);
        r = cyc;
        push_burst(c + 3, r - c - 2);
        reset        = 1'b1;
        swith_select = '0;
        @(negedge fastclk);
        check_zero("reset_run");
        model_total = '0;
        reset = 1'b0;
        repeat (5) @(negedge fastclk);

        check("bursts_drained", 64'(exp_burst.size()), 64'(0));
        check("scan_left", 64'(exp_scan.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
